// File: rtl/interconnect_pkg.sv
// Shared definitions for the ingress-to-egress round-robin interconnect:
// FSM encodings, port count and destination-field width.
package interconnect_pkg;

  localparam int N_PORTS = 4;
  localparam int DEST_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_STALL = 2'd2
  } arb_state_e;

  function automatic logic [N_PORTS-1:0] dest_onehot(input logic [DEST_W-1:0] dest);
    dest_onehot       = '0;
    dest_onehot[dest] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin grant: first requester after last_grant, wrapping,
// with last_grant itself searched last.
module rr_grant
  import interconnect_pkg::*;
(
  input  logic [N_PORTS-1:0] req,
  input  logic [DEST_W-1:0]  last_grant,
  output logic [N_PORTS-1:0] grant,
  output logic [DEST_W-1:0]  grant_idx
);

  logic              found;
  logic [DEST_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = last_grant;
    found     = 1'b0;
    idx       = last_grant;
    for (int k = 1; k <= N_PORTS; k++) begin
      idx = last_grant + DEST_W'(k);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/round_robin_arbiter.sv
// Drains four input FIFOs round-robin and routes each word to the output FIFO
// named by its two destination MSBs, through a two-stage pop-to-push pipeline.
module round_robin_arbiter
  import interconnect_pkg::*;
#(
  parameter int WORD_SIZE = 6
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_PORTS-1:0]             fifo_empty,
  input  logic [N_PORTS*WORD_SIZE-1:0]   data_in,
  input  logic [N_PORTS-1:0]             almost_full,
  output logic [N_PORTS-1:0]             fifo_rd,
  output logic [N_PORTS-1:0]             push,
  output logic [WORD_SIZE-1:0]           data_out,
  output logic [1:0]                     state
);

  arb_state_e               state_q, state_d;
  logic [DEST_W-1:0]        last_grant_q, last_grant_d;
  logic                     rd_vld_p1_q, rd_vld_p1_d;
  logic [DEST_W-1:0]        rd_sel_p1_q, rd_sel_p1_d;
  logic [N_PORTS-1:0]       push_p2_q, push_p2_d;
  logic [WORD_SIZE-1:0]     data_p2_q, data_p2_d;

  logic                     any_full;
  logic                     any_req;
  logic                     pop_en;
  logic                     pop;
  logic [N_PORTS-1:0]       req;
  logic [N_PORTS-1:0]       grant;
  logic [DEST_W-1:0]        grant_idx;
  logic [N_PORTS-1:0]       fifo_rd_c;
  logic [WORD_SIZE-1:0]     sel_word_p1;

  assign req      = ~fifo_empty;
  assign any_req  = |req;
  assign any_full = |almost_full;

  rr_grant u_grant (
    .req        (req),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // Stall is global: the destination of the next word is unknown until after its pop.
  always_comb begin
    pop_en    = (state_q == ST_ARB) && !any_full && !reset;
    fifo_rd_c = pop_en ? grant : '0;
    pop       = |fifo_rd_c;

    if (any_full)     state_d = ST_STALL;
    else if (any_req) state_d = ST_ARB;
    else              state_d = ST_IDLE;

    last_grant_d = pop ? grant_idx : last_grant_q;
    rd_vld_p1_d  = pop;
    rd_sel_p1_d  = pop ? grant_idx : rd_sel_p1_q;

    sel_word_p1 = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (rd_sel_p1_q == DEST_W'(k)) sel_word_p1 = data_in[k*WORD_SIZE +: WORD_SIZE];
    end

    push_p2_d = rd_vld_p1_q ? dest_onehot(sel_word_p1[WORD_SIZE-1 -: DEST_W]) : '0;
    data_p2_d = rd_vld_p1_q ? sel_word_p1 : data_p2_q;
  end

  // Stage p1: pop registered; stage p2: popped word captured and routed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= DEST_W'(N_PORTS-1);
      rd_vld_p1_q  <= 1'b0;
      push_p2_q    <= '0;
      data_p2_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rd_vld_p1_q  <= rd_vld_p1_d;
      push_p2_q    <= push_p2_d;
      data_p2_q    <= data_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    rd_sel_p1_q <= rd_sel_p1_d;
  end

  assign fifo_rd  = fifo_rd_c;
  assign push     = reset ? '0 : push_p2_q;
  assign data_out = data_p2_q;
  assign state    = state_q;

endmodule
